// File: rtl/segway_math.sv
// segway_math: soft-start scaling, steering mix, low-torque shaping and saturation
// in a 3-stage valid pipeline, plus a sustained-overspeed detector on the outputs.
module segway_math #(
  parameter logic [11:0] MIN_DUTY        = 12'h0A8,
  parameter logic [7:0]  LOW_TORQUE_BAND = 8'h2A,
  parameter logic [3:0]  GAIN_MULT       = 4'h4,
  parameter logic [11:0] TOO_FAST_LIM    = 12'd1536,
  parameter logic [2:0]  TOO_FAST_CNT    = 3'd4
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_in,
  input  logic [11:0] PID_cntrl,
  input  logic [7:0]  ss_tmr,
  input  logic [11:0] steer_pot,
  input  logic        en_steer,
  input  logic        pwr_up,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        vld_out,
  output logic        too_fast
);
  logic signed [20:0] prod;
  logic [11:0] steer_c;
  logic signed [15:0] steer_m;
  logic signed [12:0] pid_ss, steer_s, lft_n, rght_n, lft1, rght1;
  logic signed [13:0] lft2, rght2;
  logic vld1, vld2, over;
  logic [2:0] cnt;

  function automatic logic signed [13:0] shape(input logic signed [12:0] t);
    logic signed [13:0] te, md, gm;
    logic [12:0] mag;
    te = {t[12], t};
    md = {2'b0, MIN_DUTY};
    gm = {10'b0, GAIN_MULT};
    mag = t[12] ? -t : t;
    shape = (mag >= {5'b0, LOW_TORQUE_BAND}) ? (t[12] ? te - md : te + md) : te * gm;
  endfunction

  function automatic logic [11:0] sat(input logic signed [13:0] v);
    sat = (v > 14'sd2047) ? 12'h7FF : (v < -14'sd2048) ? 12'h800 : v[11:0];
  endfunction

  // the product fits in 20 bits, so taking [20:8] equals sign-extending [19:8]
  always_comb begin
    prod = $signed({{9{PID_cntrl[11]}}, PID_cntrl}) * $signed({13'b0, ss_tmr});
    pid_ss = 13'(prod >>> 8);
    steer_c = steer_pot < 12'h200 ? 12'h200 : steer_pot > 12'hE00 ? 12'hE00 : steer_pot;
    steer_m = ($signed({4'b0, steer_c}) - 16'sd2047) * 16'sd3;
    steer_s = 13'(steer_m >>> 4);
    lft_n = en_steer ? pid_ss + steer_s : pid_ss;
    rght_n = en_steer ? pid_ss - steer_s : pid_ss;
  end

  assign over = $signed(lft_spd) > $signed(TOO_FAST_LIM) || $signed(rght_spd) > $signed(TOO_FAST_LIM);
  assign too_fast = cnt == TOO_FAST_CNT;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld1 <= 1'b0;
      vld2 <= 1'b0;
      vld_out <= 1'b0;
      lft1 <= '0;
      rght1 <= '0;
      lft2 <= '0;
      rght2 <= '0;
      lft_spd <= '0;
      rght_spd <= '0;
      cnt <= '0;
    end else begin
      vld1 <= vld_in;
      vld2 <= vld1;
      vld_out <= vld2;
      if (vld_in) begin
        lft1 <= lft_n;
        rght1 <= rght_n;
      end
      if (vld1) begin
        lft2 <= pwr_up ? shape(lft1) : '0;
        rght2 <= pwr_up ? shape(rght1) : '0;
      end
      if (vld2) begin
        lft_spd <= sat(lft2);
        rght_spd <= sat(rght2);
      end
      if (!pwr_up) cnt <= '0;
      else if (vld_out) cnt <= over ? (cnt == TOO_FAST_CNT ? cnt : cnt + 3'd1) : '0;
    end
endmodule

// File: tb/tb_segway_math.sv
// tb_segway_math: directed and randomized stimulus checked against an arithmetic
// reference model with a fixed three-cycle latency.
module tb_segway_math;
  logic clk = 0, rst_n = 0, vld_in = 0, en_steer = 0, pwr_up = 0;
  logic [11:0] PID_cntrl = 0, steer_pot = 0;
  logic [7:0] ss_tmr = 0;
  logic [11:0] lft_spd, rght_spd;
  logic vld_out, too_fast;
  int checks = 0, passed = 0;

  typedef struct {
    bit v;
    logic [11:0] pid;
    logic [7:0] ss;
    logic [11:0] pot;
    bit en;
    bit pwr;
  } in_t;

  in_t d1 = '{default: 0}, d2 = '{default: 0};
  logic [11:0] el = 0, er = 0;
  bit ev = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  segway_math dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .PID_cntrl(PID_cntrl), .ss_tmr(ss_tmr),
    .steer_pot(steer_pot), .en_steer(en_steer), .pwr_up(pwr_up), .lft_spd(lft_spd),
    .rght_spd(rght_spd), .vld_out(vld_out), .too_fast(too_fast)
  );

  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int shape(int t, bit p);
    if (!p) return 0;
    if ((t < 0 ? -t : t) >= 42) return t >= 0 ? t + 168 : t - 168;
    return t * 4;
  endfunction

  function automatic logic [11:0] sat(int v);
    return v > 2047 ? 12'h7FF : v < -2048 ? 12'h800 : 12'(v);
  endfunction

  task automatic calc(input in_t s, input bit p, output logic [11:0] l, output logic [11:0] r);
    int pi, si, ps, c, st, lt, rt;
    pi = $signed(s.pid);
    si = s.ss;
    ps = (pi * si) >>> 8;
    c = s.pot;
    c = c < 512 ? 512 : (c > 3584 ? 3584 : c);
    st = ((c - 2047) * 3) >>> 4;
    lt = s.en ? ps + st : ps;
    rt = s.en ? ps - st : ps;
    l = sat(shape(lt, p));
    r = sat(shape(rt, p));
  endtask

  task automatic check_all(string tag);
    chk({tag, "_lft"}, lft_spd, el);
    chk({tag, "_rght"}, rght_spd, er);
    chk({tag, "_vld"}, 12'(vld_out), 12'(ev));
    chk({tag, "_tf"}, 12'(too_fast), 12'(ecnt == 4));
  endtask

  task automatic step(bit v, logic [11:0] pid, logic [7:0] ss, logic [11:0] pot, bit en, bit pw);
    in_t cur;
    bit over;
    @(negedge clk);
    vld_in = v; PID_cntrl = pid; ss_tmr = ss; steer_pot = pot; en_steer = en; pwr_up = pw;
    @(posedge clk);
    cur = '{v, pid, ss, pot, en, pw};
    if (!rst_n) begin
      d1.v = 0; d2.v = 0; ev = 0; el = 0; er = 0; ecnt = 0;
    end else begin
      over = $signed(el) > 1536 || $signed(er) > 1536;
      if (!pw) ecnt = 0;
      else if (ev) ecnt = over ? (ecnt < 4 ? ecnt + 1 : 4) : 0;
      ev = d2.v;
      if (d2.v) calc(d2, d1.pwr, el, er);
      d2 = d1;
      d1 = cur;
    end
    #1;
    check_all("step");
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 12'h0, 8'h0, 12'h800, 0, 1);
  endtask

  initial begin
    logic [11:0] r;
    step(1, 12'h100, 8'hFF, 12'h0, 0, 1);
    step(0, 12'h0, 8'h0, 12'h0, 0, 1);
    @(negedge clk) rst_n = 1;
    // unsteered nominal drive
    step(1, 12'h100, 8'hFF, 12'h800, 0, 1);
    idle(2);
    chk("r030_vld", 12'(vld_out), 12'h1);
    chk("r030_lft", lft_spd, 12'h1A7);
    chk("r030_rght", rght_spd, 12'h1A7);
    idle(1);
    chk("r030_vld_drop", 12'(vld_out), 12'h0);
    // low-band gain, positive and negative
    step(1, 12'h010, 8'hFF, 12'h800, 0, 1);
    step(1, 12'hFF0, 8'hFF, 12'h800, 0, 1);
    idle(1);
    chk("r031_pos", lft_spd, 12'h03C);
    idle(1);
    chk("r031_neg", rght_spd, 12'hFC0);
    // full steer, zero torque
    step(1, 12'h0, 8'hFF, 12'hFFF, 1, 1);
    idle(2);
    chk("r032_lft", lft_spd, 12'h1C8);
    chk("r032_rght", rght_spd, 12'hE38);
    // overspeed run then release
    for (int i = 0; i < 8; i++) step(1, 12'h7FF, 8'hFF, 12'hFFF, 1, 1);
    chk("r033_lft", lft_spd, 12'h7FF);
    chk("r033_rght", rght_spd, 12'h77F);
    chk("r033_tf", 12'(too_fast), 12'h1);
    step(1, 12'h0, 8'hFF, 12'hFFF, 1, 1);
    idle(3);
    chk("r033_tf_clr", 12'(too_fast), 12'h0);
    // back-to-back distinct samples
    step(1, 12'h123, 8'h80, 12'h300, 1, 1);
    step(1, 12'hE45, 8'hC0, 12'hD00, 1, 1);
    step(1, 12'h005, 8'h40, 12'h100, 0, 1);
    idle(3);
    // overspeed then drive disable
    for (int i = 0; i < 7; i++) step(1, 12'h7FF, 8'hFF, 12'hFFF, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 12'h7FF, 8'hFF, 12'hFFF, 1, 0);
    chk("r034_pwr_lft", lft_spd, 12'h0);
    chk("r034_pwr_tf", 12'(too_fast), 12'h0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = 12'($urandom);
      step($urandom % 4 != 0,
           ($urandom % 3 == 0) ? {{6{r[5]}}, r[5:0]} : r,
           8'($urandom), 12'($urandom), 1'($urandom), $urandom % 16 != 0);
    end
    // reset in the middle of a transaction
    step(1, 12'h100, 8'hFF, 12'h800, 0, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    ev = 0; el = 0; er = 0; ecnt = 0; d1.v = 0; d2.v = 0;
    check_all("r035_async");
    step(0, 12'h0, 8'h0, 12'h0, 0, 1);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("r035_no_vld", 12'(vld_out), 12'h0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
